vec_alu_sequencer: RTL and testbench

Multi-beat sequencer that executes a full VECTOR_SIZE-bit vector ALU operation on a narrow ALU slice of SLICE_LANES lanes, one slice per cycle.
- Latches a request (A, B, opcode) via valid/ready.
- Walks the lane slices low-to-high through the external combinational slice.
- Assembles the result and returns it via valid/ready.
- Sits between the vector issue stage and a shared, area-reduced alu_element_vec slice.

---
 rtl/vec_alu_sequencer.sv | 131 +++++++++++++
 tb/tb_vec_alu_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/vec_alu_sequencer.sv
// Multi-beat sequencer: runs a VECTOR_SIZE-bit ALU op through a narrow external slice, low beat first.
// Optional perf counters (perf_ops, perf_stall) enabled by defining VEC_SEQ_PERF_CNT_EN.
module vec_alu_sequencer #(
  parameter int unsigned VECTOR_SIZE = 256,
  parameter int unsigned ELEMENT     = 16,
  parameter int unsigned SLICE_LANES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [VECTOR_SIZE-1:0]         req_a,
  input  logic [VECTOR_SIZE-1:0]         req_b,
  input  logic [2:0]                     req_opcode,
  output logic [ELEMENT*SLICE_LANES-1:0] slice_a,
  output logic [ELEMENT*SLICE_LANES-1:0] slice_b,
  output logic [2:0]                     slice_opcode,
  input  logic [ELEMENT*SLICE_LANES-1:0] slice_result,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [VECTOR_SIZE-1:0]         rsp_result,
  output logic                           busy
`ifdef VEC_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]                    perf_ops,
  output logic [31:0]                    perf_stall
`endif
);

  localparam int unsigned W      = ELEMENT * SLICE_LANES;
  localparam int unsigned BEATS  = VECTOR_SIZE / W;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (VECTOR_SIZE % W != 0) begin : g_size_check
    $error("vec_alu_sequencer: VECTOR_SIZE must be a multiple of ELEMENT*SLICE_LANES");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                 state_q, state_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [VECTOR_SIZE-1:0] opa_q, opa_d;
  logic [VECTOR_SIZE-1:0] opb_q, opb_d;
  logic [2:0]             opcode_q, opcode_d;
  logic [VECTOR_SIZE-1:0] result_q, result_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      beat_q   <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      opcode_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      opcode_q <= opcode_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    opcode_d     = opcode_q;
    result_d     = result_q;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    busy         = 1'b0;
    slice_a      = '0;
    slice_b      = '0;
    slice_opcode = '0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          opa_d    = req_a;
          opb_d    = req_b;
          opcode_d = req_opcode;
          beat_d   = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        busy         = 1'b1;
        slice_a      = opa_q[beat_q*W +: W];
        slice_b      = opb_q[beat_q*W +: W];
        slice_opcode = opcode_q;
        result_d[beat_q*W +: W] = slice_result;
        // Explicit wrap keeps non-power-of-two beat counts correct.
        if (beat_q == BEAT_W'(BEATS - 1)) begin
          beat_d  = '0;
          state_d = StDone;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      StDone: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign rsp_result = result_q;

`ifdef VEC_SEQ_PERF_CNT_EN
  logic [31:0] perf_ops_q, perf_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (rsp_valid && rsp_ready) perf_ops_q <= perf_ops_q + 32'd1;
      if (state_q == StDone && !rsp_ready) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_ops   = perf_ops_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Directed self-checking bench for vec_alu_sequencer with a lane-wise add/xor slice model.
module tb_vec_alu_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready;
  logic [255:0] req_a, req_b;
  logic [2:0]   req_opcode;
  logic [31:0]  slice_a, slice_b, slice_result;
  logic [2:0]   slice_opcode;
  logic         rsp_valid, rsp_ready;
  logic [255:0] rsp_result;
  logic         busy;
`ifdef VEC_SEQ_PERF_CNT_EN
  logic [31:0]  perf_ops, perf_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  vec_alu_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_opcode   (req_opcode),
    .slice_a      (slice_a),
    .slice_b      (slice_b),
    .slice_opcode (slice_opcode),
    .slice_result (slice_result),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .busy         (busy)
`ifdef VEC_SEQ_PERF_CNT_EN
    ,
    .perf_ops     (perf_ops),
    .perf_stall   (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // Slice model: opcode 000 is lane-wise add mod 2^16, 101 is lane-wise xor.
  always_comb begin
    slice_result = '0;
    for (int l = 0; l < 2; l++) begin
      if (slice_opcode == 3'b101) slice_result[l*16 +: 16] = slice_a[l*16 +: 16] ^ slice_b[l*16 +: 16];
      else                        slice_result[l*16 +: 16] = slice_a[l*16 +: 16] + slice_b[l*16 +: 16];
    end
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] lane_add(input logic [255:0] a, input logic [255:0] b);
    logic [255:0] r;
    for (int i = 0; i < 16; i++) r[i*16 +: 16] = a[i*16 +: 16] + b[i*16 +: 16];
    return r;
  endfunction

  // Issue one request, check latency/result, optionally stall the response and scramble inputs.
  task automatic run_req(input logic [255:0] a, input logic [255:0] b, input logic [2:0] op,
                         input logic [255:0] exp, input bit scramble, input bit beat_chk,
                         input int stall_cycles, input string tag);
    int n;
    logic [255:0] held;
    @(negedge clk);
    rsp_ready  = (stall_cycles == 0);
    check_eq({tag, "_req_ready"}, req_ready, 1'b1);
    req_a      = a;
    req_b      = b;
    req_opcode = op;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    if (scramble) begin
      req_a      = ~a;
      req_b      = a ^ b ^ {8{32'hDEAD_BEEF}};
      req_opcode = ~op;
    end
    while (rsp_valid !== 1'b1 && n < 20) begin
      if (beat_chk && n <= 8) begin
        check_eq($sformatf("%s_slice_a_beat%0d", tag, n - 1), slice_a, a[(n-1)*32 +: 32]);
        if (n == 1) check_eq({tag, "_slice_opcode"}, slice_opcode, op);
      end
      @(negedge clk);
      n++;
    end
    // Accept edge counts as cycle 1; response expected in cycle 9.
    check_eq({tag, "_latency"}, n, 9);
    check_eq({tag, "_result"}, rsp_result, exp);
    held = rsp_result;
    for (int s = 0; s < stall_cycles; s++) begin
      req_valid = 1'b1;
      @(negedge clk);
      check_eq($sformatf("%s_stall%0d_valid", tag, s), rsp_valid, 1'b1);
      check_eq($sformatf("%s_stall%0d_ready", tag, s), req_ready, 1'b0);
      check_eq($sformatf("%s_stall%0d_hold", tag, s), rsp_result, held);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check_eq({tag, "_post_valid"}, rsp_valid, 1'b0);
    check_eq({tag, "_post_idle"}, {busy, req_ready}, 2'b01);
  endtask

  logic [255:0] a1, b1, e1, a2, b2, e2, a3, b3, a4, b4, a5, b5;
  bit           saw_rsp;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      a1[i*16 +: 16] = 16'(i);
      b1[i*16 +: 16] = 16'h0001;
      e1[i*16 +: 16] = 16'(i + 1);
      a2[i*16 +: 16] = 16'hFFFF;
      b2[i*16 +: 16] = 16'h0002;
      e2[i*16 +: 16] = 16'h0001;
      a3[i*16 +: 16] = 16'h0100 * 16'(i) + 16'h0007;
      b3[i*16 +: 16] = 16'h00F0 + 16'(i);
      a4[i*16 +: 16] = 16'hA000 + 16'h0111 * 16'(i);
      b4[i*16 +: 16] = 16'h1234;
      a5[i*16 +: 16] = 16'h5A00 | 16'(i);
      b5[i*16 +: 16] = 16'h0FF0;
    end

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_a      = '0;
    req_b      = '0;
    req_opcode = '0;
    rsp_ready  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check_eq($sformatf("idle%0d", c), {req_ready, rsp_valid, busy}, 3'b100);
      check_eq($sformatf("idle%0d_slice_a", c), slice_a, 32'h0);
    end
    check_eq("reset_result", rsp_result, '0);

    run_req(a1, b1, 3'b000, e1, 1'b0, 1'b1, 0, "add");
`ifdef VEC_SEQ_PERF_CNT_EN
    check_eq("perf_ops_1", perf_ops, 32'd1);
`endif
    run_req(a2, b2, 3'b000, e2, 1'b0, 1'b0, 0, "wrap");
    run_req(a3, b3, 3'b000, lane_add(a3, b3), 1'b0, 1'b0, 5, "bp");
`ifdef VEC_SEQ_PERF_CNT_EN
    check_eq("perf_stall_5", perf_stall, 32'd5);
    check_eq("perf_ops_3", perf_ops, 32'd3);
`endif

    // Reset during beat 4 drops the operation.
    @(negedge clk);
    req_a      = a3;
    req_b      = b3;
    req_opcode = 3'b000;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("rst_beat4_slice", slice_a, a3[4*32 +: 32]);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_async_state", {req_ready, rsp_valid, busy}, 3'b100);
    check_eq("rst_async_slice", slice_a, 32'h0);
    check_eq("rst_async_result", rsp_result, '0);
`ifdef VEC_SEQ_PERF_CNT_EN
    check_eq("rst_perf_ops", perf_ops, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    saw_rsp = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) saw_rsp = 1'b1;
    end
    check_eq("rst_no_rsp", saw_rsp, 1'b0);
    run_req(a1, b1, 3'b000, e1, 1'b0, 1'b0, 0, "after_rst");

    run_req(a4, b4, 3'b000, lane_add(a4, b4), 1'b1, 1'b1, 0, "scramble");
    run_req(a5, b5, 3'b101, a5 ^ b5, 1'b0, 1'b1, 0, "xor");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
